// File: rtl/burst_scheduler_if.sv
// Burst scheduler signal bundle.
// master: the interrupter side that raises req/ocd/fault_clr and observes the status.
// slave : the scheduler itself.
// req and ocd are level signals from asynchronous sources. fault_clr is a single-cycle
// pulse in the clk domain. The outputs are levels decoded from the scheduler state.
interface burst_scheduler_if #(
    parameter int STRIKES_W = 2
);
    logic                 req;
    logic                 ocd;
    logic                 fault_clr;
    logic                 en;
    logic                 sel_hold;
    logic                 busy;
    logic                 fault;
    logic [STRIKES_W-1:0] strikes;

    modport master (
        output req, ocd, fault_clr,
        input  en, sel_hold, busy, fault, strikes
    );

    modport slave (
        input  req, ocd, fault_clr,
        output en, sel_hold, busy, fault, strikes
    );
endinterface

// File: rtl/burst_scheduler.sv
// burst_scheduler: turns the fibre interrupter request into bounded bursts.
// Each burst is capped at ON_MAX cycles and followed by at least OFF_MIN cycles of
// cooldown. An overcurrent aborts the burst. OCD_TRIP_N consecutive overcurrent
// aborts latch a fault, which needs fault_clr (with req low) to clear.
// Optional macro BURST_SCHEDULER_DUTY_LIMIT_EN: when defined, the cooldown stretches
// to max(OFF_MIN, burst_length*OFF_RATIO) cycles.
module burst_scheduler #(
    parameter int CLK_MHZ         = 100,
    parameter int ON_TIME_MAX_US  = 200,
    parameter int OFF_TIME_MIN_US = 1000,
    parameter int OCD_TRIP_N      = 3,
    parameter int OFF_RATIO       = 10
) (
    input  logic              clk,
    input  logic              rst,
    burst_scheduler_if.slave  bus
);
    localparam int ON_MAX  = CLK_MHZ * ON_TIME_MAX_US;
    localparam int OFF_MIN = CLK_MHZ * OFF_TIME_MIN_US;
`ifdef BURST_SCHEDULER_DUTY_LIMIT_EN
    localparam int PROD_MAX = ON_MAX * OFF_RATIO;
    localparam int PROD_W   = $clog2(PROD_MAX) + 1;
    localparam int OFF_MAX  = (PROD_MAX > OFF_MIN) ? PROD_MAX : OFF_MIN;
`else
    localparam int OFF_MAX  = OFF_MIN;
`endif
    localparam int ON_W  = $clog2(ON_MAX) + 1;
    localparam int OFF_W = $clog2(OFF_MAX) + 1;
    localparam int STR_W = $clog2(OCD_TRIP_N + 1);

    localparam logic [ON_W-1:0]  ON_LOAD  = ON_W'(ON_MAX - 1);
    localparam logic [OFF_W-1:0] OFF_LOAD = OFF_W'(OFF_MIN - 1);
    localparam logic [STR_W-1:0] STR_TRIP = STR_W'(OCD_TRIP_N);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ON       = 2'd1,
        COOLDOWN = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ON_W-1:0]   on_cnt_q, on_cnt_d;
    logic [OFF_W-1:0]  off_cnt_q, off_cnt_d;
    logic [STR_W-1:0]  strikes_q, strikes_d;
    logic [STR_W-1:0]  strikes_inc;
    logic [OFF_W-1:0]  cool_load;

    logic req_m, req_s, req_d;
    logic ocd_m, ocd_s;
    logic req_rise;

    // Two-flop synchronisers. req history resets high so a req held through reset
    // never looks like a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_m <= 1'b1;
            req_s <= 1'b1;
            req_d <= 1'b1;
            ocd_m <= 1'b0;
            ocd_s <= 1'b0;
        end else begin
            req_m <= bus.req;
            req_s <= req_m;
            req_d <= req_s;
            ocd_m <= bus.ocd;
            ocd_s <= ocd_m;
        end
    end

    assign req_rise    = req_s & ~req_d;
    assign strikes_inc = strikes_q + STR_W'(1);

`ifdef BURST_SCHEDULER_DUTY_LIMIT_EN
    logic [ON_W-1:0]   elapsed_q;
    logic [PROD_W-1:0] burst_len;
    logic [PROD_W-1:0] cool_prod;

    // Counts cycles spent in ON; it sits at zero outside a burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elapsed_q <= '0;
        end else if (state_q == ON) begin
            elapsed_q <= elapsed_q + ON_W'(1);
        end else begin
            elapsed_q <= '0;
        end
    end

    // Cooldown reload: the longer of OFF_MIN and burst length times OFF_RATIO.
    always_comb begin
        burst_len = PROD_W'(elapsed_q) + PROD_W'(1);
        cool_prod = burst_len * PROD_W'(OFF_RATIO);
        if (OFF_W'(cool_prod) > OFF_W'(OFF_MIN)) begin
            cool_load = OFF_W'(cool_prod) - OFF_W'(1);
        end else begin
            cool_load = OFF_LOAD;
        end
    end
`else
    assign cool_load = OFF_LOAD;
`endif

    // State register together with the burst, cooldown and strike counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            on_cnt_q  <= '0;
            off_cnt_q <= '0;
            strikes_q <= '0;
        end else begin
            state_q   <= state_d;
            on_cnt_q  <= on_cnt_d;
            off_cnt_q <= off_cnt_d;
            strikes_q <= strikes_d;
        end
    end

    // Next-state and counter update. ON exits are checked as overcurrent first,
    // then request drop, then timeout.
    always_comb begin
        state_d   = state_q;
        on_cnt_d  = on_cnt_q;
        off_cnt_d = off_cnt_q;
        strikes_d = strikes_q;
        unique case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d  = ON;
                    on_cnt_d = ON_LOAD;
                end
            end
            ON: begin
                if (ocd_s) begin
                    strikes_d = strikes_inc;
                    if (strikes_inc == STR_TRIP) begin
                        state_d = FAULT;
                    end else begin
                        state_d   = COOLDOWN;
                        off_cnt_d = cool_load;
                    end
                end else if (!req_s || (on_cnt_q == '0)) begin
                    state_d   = COOLDOWN;
                    off_cnt_d = cool_load;
                    strikes_d = '0;
                end else begin
                    on_cnt_d = on_cnt_q - ON_W'(1);
                end
            end
            COOLDOWN: begin
                if (off_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    off_cnt_d = off_cnt_q - OFF_W'(1);
                end
            end
            FAULT: begin
                // Clearing is only honoured once the request has been released.
                if (bus.fault_clr && !req_s) begin
                    state_d   = COOLDOWN;
                    off_cnt_d = OFF_LOAD;
                    strikes_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded straight from the state register.
    always_comb begin
        bus.en       = (state_q == ON);
        bus.sel_hold = (state_q != ON);
        bus.busy     = (state_q == ON) || (state_q == COOLDOWN);
        bus.fault    = (state_q == FAULT);
        bus.strikes  = strikes_q;
    end
endmodule

// File: doc/burst_scheduler.md
Name: burst_scheduler

Overview:
- Interrupter-side controller that sequences the gen/fb selector and the bridge driver.
- Converts the fibre interrupter request into bounded bursts: enforces maximum on-time and minimum off-time, aborts on overcurrent, and latches a fault after repeated overcurrent bursts.
- Holds the selector in its startup (gen) mode between bursts, so every burst begins from the generator.

Parameters:
- CLK_MHZ, 100, clock frequency in MHz.
- ON_TIME_MAX_US, 200, maximum burst length in us; ON_MAX = CLK_MHZ*ON_TIME_MAX_US cycles.
- OFF_TIME_MIN_US, 1000, minimum gap after any burst in us; OFF_MIN = CLK_MHZ*OFF_TIME_MIN_US cycles.
- OCD_TRIP_N, 3, number of consecutive OCD-terminated bursts that latches a fault (>=1).
- OFF_RATIO, 10, cooldown multiplier for the optional duty limit.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req  input  1  interrupter request, asynchronous; high = burst wanted
- ocd  input  1  overcurrent detect, asynchronous, active-high
- fault_clr  input  1  single-cycle fault acknowledge
- en  output  1  driver enable; high only in ON
- sel_hold  output  1  holds the selector in gen mode; equals ~en
- busy  output  1  high in ON or COOLDOWN
- fault  output  1  high in FAULT
- strikes  output  $clog2(OCD_TRIP_N+1)  current consecutive-OCD count

Behaviour:
- Synchronisers:
  - req and ocd each pass through a 2-flop synchroniser (req_s, ocd_s).
  - On rst, the req flops and the req edge-detector history reset to 1; the ocd flops reset to 0.
  - Consequence: a req held high through reset never starts a burst. req must go low, then high.
- Reset: state=IDLE, all counters 0, strikes=0, en=0, sel_hold=1, busy=0, fault=0. Outputs take these values immediately on rst assertion.
- All outputs are decoded combinationally from the state register. There are no other output registers.
- Counter widths are $clog2 of the largest loaded value plus 1. Counters saturate at 0 and never wrap.
- IDLE:
  - A rising edge on req_s moves to ON on that edge and loads on_cnt = ON_MAX-1.
  - en goes high after the 3rd rising clk edge following the req rise.
- ON, exit checks in priority order:
  - 1. ocd_s=1: strikes+1. If the new value equals OCD_TRIP_N, go to FAULT; otherwise go to COOLDOWN.
  - 2. req_s=0: go to COOLDOWN and clear strikes to 0.
  - 3. on_cnt=0: go to COOLDOWN and clear strikes to 0 (timeout, burst length exactly ON_MAX cycles).
  - Otherwise on_cnt decrements.
  - ocd and a req fall on the same cycle count as an OCD exit.
- COOLDOWN:
  - Entry loads off_cnt = OFF_MIN-1. off_cnt decrements each cycle; at 0, go to IDLE.
  - req edges during COOLDOWN are ignored.
  - On entering IDLE, a req that is still high does not start a burst; a new rising edge is required.
- FAULT:
  - en=0, fault=1. Stays in FAULT until fault_clr=1 while req_s=0.
  - That clear goes to COOLDOWN (full OFF_MIN) and sets strikes to 0.
  - fault_clr while req_s=1 is ignored.
- fault_clr in any state other than FAULT has no effect.
- rst during ON drops en asynchronously. No cooldown is enforced after a reset.

Optional Feature:
- Macro: BURST_SCHEDULER_DUTY_LIMIT_EN.
- Defined:
  - An elapsed-cycle counter runs during ON.
  - Cooldown length becomes max(OFF_MIN, elapsed*OFF_RATIO) cycles.
  - The multiply is sized for ON_MAX*OFF_RATIO, with no overflow.
- Undefined: cooldown is always OFF_MIN. OFF_RATIO is unused and the elapsed counter is not built.

Test Plan:
All scenarios use CLK_MHZ=10, ON_TIME_MAX_US=5 (ON_MAX=50), OFF_TIME_MIN_US=10 (OFF_MIN=100), OCD_TRIP_N=3.
- req rise, held 20 cycles, then falls -> en rises 3 edges after the req rise and stays high 20 cycles; busy stays high a further 100 cycles; strikes=0.
- req held high 200 cycles -> en high exactly 50 cycles, then 100 cycles of cooldown, then IDLE with en=0 while req is still high; a new req edge restarts the burst.
- A second req edge 30 cycles into cooldown -> ignored; en stays 0 until req rises again after IDLE.
- ocd pulse during each of 3 consecutive bursts -> strikes goes 1, 2, then FAULT with fault=1 and en=0; fault_clr with req high is ignored; fault_clr with req low -> COOLDOWN, strikes=0.
- rst asserted mid-burst with req held high -> en=0 immediately; after release, no burst until req goes low then high.
- With BURST_SCHEDULER_DUTY_LIMIT_EN and OFF_RATIO=10, a 30-cycle burst -> cooldown 300 cycles; a 5-cycle burst -> cooldown 100 cycles.
